// File: rtl/idt_cfg_ctrl.sv
// idt_cfg_ctrl
// Serial configuration controller for an IDT clock synthesizer. A 24-bit
// config word {C[1:0],TTL,F[1:0],S[2:0],V[8:0],R[6:0]} is shifted out MSB
// first on idt_data/idt_sclk (device samples on the idt_sclk rising edge),
// then latched into the device with an idt_strobe pulse.
//
// Handshake: a word transfers on a rising osc_clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high only while the FSM is IDLE, so
// cfg_valid/cfg_data are ignored while a sequence is in flight; the word is
// captured at the accept edge and later cfg_data changes have no effect.
//
// Ports:
//   osc_clk     in   single clock, rising edge
//   osc_reset_  in   asynchronous active-low reset
//   cfg_valid   in   cfg_data holds a word to program
//   cfg_data    in   24-bit config word
//   cfg_ready   out  high only in IDLE
//   busy        out  high whenever the FSM is not IDLE
//   done        out  one-cycle pulse in the first IDLE cycle after STROBE
//   idt_sclk    out  serial clock to the device
//   idt_data    out  serial data, bit 23 first
//   idt_strobe  out  load strobe
//   fsm_state   out  current FSM state encoding (debug observation)
//
// Parameters:
//   HALF_PER    idt_sclk half-period in osc_clk cycles (1..255)
//   STROBE_LEN  idt_strobe high time in osc_clk cycles (1..255)
//   AUTO_INIT   1: program INIT_CONFIG automatically after reset
//   INIT_CONFIG power-up config word

module idt_cfg_ctrl #(
    parameter int          HALF_PER    = 4,
    parameter int          STROBE_LEN  = 8,
    parameter int          AUTO_INIT   = 1,
    parameter logic [23:0] INIT_CONFIG = 24'h31149F
) (
    input  logic        osc_clk,
    input  logic        osc_reset_,
    input  logic        cfg_valid,
    input  logic [23:0] cfg_data,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        STROBE   = 3'd3,
        AUTO     = 3'd4
    } state_t;

    localparam state_t     RESET_STATE = (AUTO_INIT == 1) ? AUTO : IDLE;
    // Phase counters count down to zero, so load with length-1.
    localparam logic [7:0] HALF_LOAD   = 8'(HALF_PER - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_LEN - 1);

    state_t      state, state_n;
    logic [23:0] word, word_n;
    logic [4:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic        done_n;
    logic        sclk_n, data_n, strobe_n, ready_n;

    assign fsm_state = state;

    always_ff @(posedge osc_clk or negedge osc_reset_) begin
        if (!osc_reset_) begin
            state      <= RESET_STATE;
            word       <= '0;
            idx        <= '0;
            cnt        <= '0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            word       <= word_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            cfg_ready  <= ready_n;
            busy       <= ~ready_n;
            done       <= done_n;
            idt_sclk   <= sclk_n;
            idt_data   <= data_n;
            idt_strobe <= strobe_n;
        end
    end

    // Next-state logic. Outputs are derived from the next state so that the
    // registered outputs line up with the state they describe: the first bit
    // appears in the cycle right after the accept edge.
    always_comb begin
        state_n = state;
        word_n  = word;
        idx_n   = idx;
        cnt_n   = cnt;
        done_n  = 1'b0;

        case (state)
            AUTO: begin
                word_n  = INIT_CONFIG;
                idx_n   = 5'd23;
                cnt_n   = HALF_LOAD;
                state_n = SHIFT_LO;
            end
            IDLE: begin
                // cfg_ready is the registered view of IDLE; it stays low on
                // the first edge after reset, so nothing is accepted there.
                if (cfg_valid && cfg_ready) begin
                    word_n  = cfg_data;
                    idx_n   = 5'd23;
                    cnt_n   = HALF_LOAD;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (cnt == 8'd0) begin
                    cnt_n   = HALF_LOAD;
                    state_n = SHIFT_HI;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (cnt == 8'd0) begin
                    if (idx != 5'd0) begin
                        idx_n   = idx - 5'd1;
                        cnt_n   = HALF_LOAD;
                        state_n = SHIFT_LO;
                    end else begin
                        cnt_n   = STROBE_LOAD;
                        state_n = STROBE;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n  = (state_n == IDLE);
        sclk_n   = (state_n == SHIFT_HI);
        strobe_n = (state_n == STROBE);
        data_n   = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? word_n[idx_n] : 1'b0;
    end

endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// Bench for idt_cfg_ctrl. Three instances share one clock:
//   u0: AUTO_INIT=1, HALF_PER=1,   STROBE_LEN=2
//   u1: AUTO_INIT=0, HALF_PER=4,   STROBE_LEN=8
//   u2: AUTO_INIT=0, HALF_PER=255, STROBE_LEN=255
// A monitor reconstructs each shifted word from idt_sclk rising edges and
// compares it, when done pulses, against the expected word queue.

module tb_idt_cfg_ctrl;

    logic        osc_clk = 1'b0;
    logic        rst_n      [3];
    logic        cfg_valid  [3];
    logic [23:0] cfg_data   [3];
    logic        cfg_ready  [3];
    logic        busy       [3];
    logic        done       [3];
    logic        sclk       [3];
    logic        sdata      [3];
    logic        strobe     [3];
    logic [2:0]  st         [3];

    int n_checks = 0;
    int n_bad    = 0;

    logic [23:0] exp_q[$];
    int          exp_inst_q[$];

    // monitor state
    logic        prev_rst   [3];
    logic        prev_sclk  [3];
    logic        prev_strb  [3];
    logic        prev_busy  [3];
    logic        prev_done  [3];
    logic [23:0] cap        [3];
    int          bits       [3];
    int          hi_run     [3];
    int          strb_run   [3];
    int          busy_run   [3];
    int          strb_total [3];

    // ---------------- clock ----------------
    always #5 osc_clk = ~osc_clk;

    // ---------------- DUTs ----------------
    idt_cfg_ctrl #(.HALF_PER(1), .STROBE_LEN(2), .AUTO_INIT(1), .INIT_CONFIG(24'h31149F)) u0 (
        .osc_clk(osc_clk), .osc_reset_(rst_n[0]), .cfg_valid(cfg_valid[0]), .cfg_data(cfg_data[0]),
        .cfg_ready(cfg_ready[0]), .busy(busy[0]), .done(done[0]), .idt_sclk(sclk[0]),
        .idt_data(sdata[0]), .idt_strobe(strobe[0]), .fsm_state(st[0]));

    idt_cfg_ctrl #(.HALF_PER(4), .STROBE_LEN(8), .AUTO_INIT(0), .INIT_CONFIG(24'h31149F)) u1 (
        .osc_clk(osc_clk), .osc_reset_(rst_n[1]), .cfg_valid(cfg_valid[1]), .cfg_data(cfg_data[1]),
        .cfg_ready(cfg_ready[1]), .busy(busy[1]), .done(done[1]), .idt_sclk(sclk[1]),
        .idt_data(sdata[1]), .idt_strobe(strobe[1]), .fsm_state(st[1]));

    idt_cfg_ctrl #(.HALF_PER(255), .STROBE_LEN(255), .AUTO_INIT(0), .INIT_CONFIG(24'h31149F)) u2 (
        .osc_clk(osc_clk), .osc_reset_(rst_n[2]), .cfg_valid(cfg_valid[2]), .cfg_data(cfg_data[2]),
        .cfg_ready(cfg_ready[2]), .busy(busy[2]), .done(done[2]), .idt_sclk(sclk[2]),
        .idt_data(sdata[2]), .idt_strobe(strobe[2]), .fsm_state(st[2]));

    // ---------------- reference parameters ----------------
    function automatic int hp(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 255;
        endcase
    endfunction

    function automatic int sl(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 255;
        endcase
    endfunction

    function automatic int seq_len(input int i);
        return 48 * hp(i) + sl(i);
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] out_vec(input int i);
        return {cfg_ready[i], busy[i], done[i], sclk[i], sdata[i], strobe[i]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            prev_rst[i] = 1'b0; prev_sclk[i] = 1'b0; prev_strb[i] = 1'b0;
            prev_busy[i] = 1'b0; prev_done[i] = 1'b0; cap[i] = '0; bits[i] = 0;
            hi_run[i] = 0; strb_run[i] = 0; busy_run[i] = 0; strb_total[i] = 0;
        end
        forever begin
            @(negedge osc_clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n[i]) begin
                    if (prev_rst[i]) begin
                        exp_q.delete();
                        exp_inst_q.delete();
                    end
                    prev_sclk[i] = 1'b0; prev_strb[i] = 1'b0; prev_busy[i] = 1'b0;
                    prev_done[i] = 1'b0; cap[i] = '0; bits[i] = 0;
                    hi_run[i] = 0; strb_run[i] = 0; busy_run[i] = 0;
                end else begin
                    check($sformatf("strobe_and_sclk%0d", i), 32'(strobe[i] & sclk[i]), 0);
                    check($sformatf("ready_and_busy%0d", i), 32'(cfg_ready[i] & busy[i]), 0);

                    if (sclk[i] && !prev_sclk[i]) begin
                        cap[i] = {cap[i][22:0], sdata[i]};
                        bits[i]++;
                    end
                    if (sclk[i]) hi_run[i]++;
                    else if (prev_sclk[i]) begin
                        check($sformatf("sclk_high_len%0d", i), hi_run[i], hp(i));
                        hi_run[i] = 0;
                    end

                    if (strobe[i]) begin
                        strb_run[i]++;
                        strb_total[i]++;
                    end else if (prev_strb[i]) begin
                        check($sformatf("strobe_len%0d", i), strb_run[i], sl(i));
                        strb_run[i] = 0;
                    end

                    if (busy[i]) busy_run[i]++;
                    else if (prev_busy[i]) begin
                        check($sformatf("busy_len%0d", i), busy_run[i], seq_len(i));
                        busy_run[i] = 0;
                    end

                    if (done[i]) begin
                        check($sformatf("done_single%0d", i), 32'(prev_done[i]), 0);
                        check($sformatf("bit_count%0d", i), bits[i], 24);
                        check($sformatf("sb_pending%0d", i), 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            logic [23:0] w;
                            int          wi;
                            w  = exp_q.pop_front();
                            wi = exp_inst_q.pop_front();
                            check($sformatf("sb_inst%0d", i), wi, i);
                            check($sformatf("shifted_word%0d", i), {8'h0, cap[i]}, {8'h0, w});
                        end
                        bits[i] = 0;
                        cap[i]  = '0;
                    end
                    prev_sclk[i] = sclk[i];
                    prev_strb[i] = strobe[i];
                    prev_busy[i] = busy[i];
                    prev_done[i] = done[i];
                end
                prev_rst[i] = rst_n[i];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int i, input logic [23:0] w);
        exp_q.push_back(w);
        exp_inst_q.push_back(i);
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!cfg_ready[i] && n < 20000) begin
            @(negedge osc_clk);
            n++;
        end
        check($sformatf("ready_wait%0d", i), 32'(cfg_ready[i]), 1);
    endtask

    task automatic wait_done(input int i, input int exp_lat);
        int lat;
        lat = 0;
        while (!done[i] && lat < exp_lat + 20) begin
            @(negedge osc_clk);
            lat++;
        end
        check($sformatf("done_latency%0d", i), lat, exp_lat);
    endtask

    // Present a word for one cycle, check the first bit, wait for done.
    task automatic send_word(input int i, input logic [23:0] w);
        wait_ready(i);
        cfg_valid[i] = 1'b1;
        cfg_data[i]  = w;
        push_exp(i, w);
        @(negedge osc_clk);
        cfg_valid[i] = 1'b0;
        cfg_data[i]  = 24'($urandom);
        check($sformatf("first_busy%0d", i), 32'(busy[i]), 1);
        check($sformatf("first_sclk%0d", i), 32'(sclk[i]), 0);
        check($sformatf("first_bit%0d", i), 32'(sdata[i]), 32'(w[23]));
        check($sformatf("first_ready%0d", i), 32'(cfg_ready[i]), 0);
        wait_done(i, seq_len(i));
    endtask

    // Hold cfg_valid high with churning cfg_data; the next word is taken in
    // the done cycle and starts immediately.
    task automatic back_to_back(input int i, input logic [23:0] a, input logic [23:0] b);
        int n;
        n = seq_len(i);
        wait_ready(i);
        cfg_valid[i] = 1'b1;
        cfg_data[i]  = a;
        push_exp(i, a);
        for (int j = 0; j < n; j++) begin
            @(negedge osc_clk);
            cfg_data[i] = 24'($urandom);
        end
        @(negedge osc_clk);
        check("b2b_done", 32'(done[i]), 1);
        check("b2b_ready", 32'(cfg_ready[i]), 1);
        cfg_data[i] = b;
        push_exp(i, b);
        @(negedge osc_clk);
        cfg_valid[i] = 1'b0;
        cfg_data[i]  = 24'($urandom);
        check("b2b_nogap_busy", 32'(busy[i]), 1);
        check("b2b_nogap_bit", 32'(sdata[i]), 32'(b[23]));
        wait_done(i, n);
    endtask

    // Abort a sequence with reset while bit 10 is on the wire.
    task automatic reset_mid(input int i, input logic [23:0] w);
        int s0;
        wait_ready(i);
        cfg_valid[i] = 1'b1;
        cfg_data[i]  = w;
        push_exp(i, w);
        @(negedge osc_clk);
        cfg_valid[i] = 1'b0;
        // bit 10 is the 14th bit: cycles 13*2*HP .. 14*2*HP-1 after accept
        repeat (13 * 2 * hp(i) + 3) @(negedge osc_clk);
        s0 = strb_total[i];
        #2 rst_n[i] = 1'b0;
        #1 check("abort_outputs", 32'(out_vec(i)), 0);
        repeat (3) @(negedge osc_clk);
        check("abort_hold_outputs", 32'(out_vec(i)), 0);
        #2 rst_n[i] = 1'b1;
        @(negedge osc_clk);
        check("abort_recover_ready", 32'(cfg_ready[i]), 1);
        repeat (2 * sl(i) + 10) @(negedge osc_clk);
        check("abort_no_strobe", strb_total[i], s0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  cyc;
        logic got;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; cfg_valid[i] = 1'b0; cfg_data[i] = '0;
        end
        repeat (3) @(negedge osc_clk);
        for (int i = 0; i < 3; i++) begin
            cfg_valid[i] = 1'b1;
            cfg_data[i]  = 24'($urandom);
        end
        @(negedge osc_clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_outputs%0d", i), 32'(out_vec(i)), 0);
            cfg_valid[i] = 1'b0;
        end

        // release all resets between edges; u0 programs its power-up word
        #2;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        push_exp(0, 24'h31149F);
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(posedge osc_clk);
            cyc++;
            @(negedge osc_clk);
            if (cyc == 1) begin
                check("auto_first_busy", 32'(busy[0]), 1);
                check("auto_first_ready", 32'(cfg_ready[0]), 0);
                check("auto_first_bit", 32'(sdata[0]), 0);
                check("noauto_first_ready", 32'(cfg_ready[1]), 1);
                check("noauto_first_busy", 32'(busy[1]), 0);
                check("noauto_first_ready2", 32'(cfg_ready[2]), 1);
            end
            if (done[0]) got = 1'b1;
        end
        check("auto_done_seen", 32'(got), 1);
        check("auto_done_cycle", cyc, 51);

        // directed word, then random words
        send_word(1, 24'hA5A5A5);
        for (int k = 0; k < 3; k++) send_word(1, 24'($urandom));
        back_to_back(1, 24'($urandom), 24'($urandom));
        reset_mid(1, 24'($urandom));
        send_word(1, 24'($urandom));

        for (int k = 0; k < 4; k++) send_word(0, 24'($urandom_range(0, 24'hFFFFFF)));
        send_word(0, 24'hFFFFFF);
        send_word(0, 24'h000000);

        send_word(2, 24'($urandom));

        repeat (5) @(negedge osc_clk);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
